// File: rtl/axi_lite_to_apb_if.sv
// AXI4-Lite slave side and APB4 master side of the axi_lite_to_apb bridge.
// The bridge binds the slave modport; the master modport is the surrounding system view.
interface axi_lite_to_apb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] aw_addr_i;
    logic [2:0]            aw_prot_i;
    logic                  aw_valid_i;
    logic                  aw_ready_o;
    logic [DATA_WIDTH-1:0] w_data_i;
    logic [STRB_WIDTH-1:0] w_strb_i;
    logic                  w_valid_i;
    logic                  w_ready_o;
    logic [1:0]            b_resp_o;
    logic                  b_valid_o;
    logic                  b_ready_i;
    logic [ADDR_WIDTH-1:0] ar_addr_i;
    logic [2:0]            ar_prot_i;
    logic                  ar_valid_i;
    logic                  ar_ready_o;
    logic [DATA_WIDTH-1:0] r_data_o;
    logic [1:0]            r_resp_o;
    logic                  r_valid_o;
    logic                  r_ready_i;

    logic [ADDR_WIDTH-1:0] paddr_o;
    logic [2:0]            pprot_o;
    logic                  psel_o;
    logic                  penable_o;
    logic                  pwrite_o;
    logic [DATA_WIDTH-1:0] pwdata_o;
    logic [STRB_WIDTH-1:0] pstrb_o;
    logic                  pready_i;
    logic [DATA_WIDTH-1:0] prdata_i;
    logic                  pslverr_i;

    modport slave (
        input  aw_addr_i, aw_prot_i, aw_valid_i, w_data_i, w_strb_i, w_valid_i,
               b_ready_i, ar_addr_i, ar_prot_i, ar_valid_i, r_ready_i,
               pready_i, prdata_i, pslverr_i,
        output aw_ready_o, w_ready_o, b_resp_o, b_valid_o, ar_ready_o,
               r_data_o, r_resp_o, r_valid_o,
               paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o
    );

    modport master (
        output aw_addr_i, aw_prot_i, aw_valid_i, w_data_i, w_strb_i, w_valid_i,
               b_ready_i, ar_addr_i, ar_prot_i, ar_valid_i, r_ready_i,
               pready_i, prdata_i, pslverr_i,
        input  aw_ready_o, w_ready_o, b_resp_o, b_valid_o, ar_ready_o,
               r_data_o, r_resp_o, r_valid_o,
               paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o
    );
endinterface

// File: rtl/axi_lite_to_apb.sv
// AXI4-Lite to APB4 bridge, one transfer at a time with read/write round-robin.
// Optional ACCESS timeout: define AXI_LITE_TO_APB_TIMEOUT_EN.
module axi_lite_to_apb #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic               clk_i,
    input logic               rst_ni,
    axi_lite_to_apb_if.slave  bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                state_r;
    logic                  last_was_write_r;
    logic                  write_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [2:0]            prot_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [STRB_WIDTH-1:0] strb_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic [1:0]            resp_r;
    logic                  psel_r;
    logic                  penable_r;
    logic                  b_valid_r;
    logic                  r_valid_r;

    logic                  wr_pend_s;
    logic                  rd_pend_s;
    logic                  grant_wr_s;
    logic                  grant_rd_s;

`ifdef AXI_LITE_TO_APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]      tmo_cnt_r;
`endif

    // Grant arbitration in IDLE: the kind not granted last wins a contended cycle.
    always_comb begin
        wr_pend_s  = bus.aw_valid_i & bus.w_valid_i;
        rd_pend_s  = bus.ar_valid_i;
        grant_wr_s = 1'b0;
        grant_rd_s = 1'b0;
        if (rst_ni && (state_r == IDLE)) begin
            if (wr_pend_s && (!rd_pend_s || !last_was_write_r)) begin
                grant_wr_s = 1'b1;
            end else if (rd_pend_s) begin
                grant_rd_s = 1'b1;
            end else begin
                grant_wr_s = 1'b0;
                grant_rd_s = 1'b0;
            end
        end else begin
            grant_wr_s = 1'b0;
            grant_rd_s = 1'b0;
        end
    end

    assign bus.aw_ready_o = grant_wr_s;
    assign bus.w_ready_o  = grant_wr_s;
    assign bus.ar_ready_o = grant_rd_s;

    assign bus.paddr_o    = addr_r;
    assign bus.pprot_o    = prot_r;
    assign bus.psel_o     = psel_r;
    assign bus.penable_o  = penable_r;
    assign bus.pwrite_o   = write_r;
    assign bus.pwdata_o   = wdata_r;
    assign bus.pstrb_o    = strb_r;
    assign bus.b_resp_o   = resp_r;
    assign bus.b_valid_o  = b_valid_r;
    assign bus.r_data_o   = rdata_r;
    assign bus.r_resp_o   = resp_r;
    assign bus.r_valid_o  = r_valid_r;

    // Transfer FSM with all request/response state held in registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r          <= IDLE;
            last_was_write_r <= 1'b0;
            write_r          <= 1'b0;
            addr_r           <= '0;
            prot_r           <= 3'b000;
            wdata_r          <= '0;
            strb_r           <= '0;
            rdata_r          <= '0;
            resp_r           <= 2'b00;
            psel_r           <= 1'b0;
            penable_r        <= 1'b0;
            b_valid_r        <= 1'b0;
            r_valid_r        <= 1'b0;
`ifdef AXI_LITE_TO_APB_TIMEOUT_EN
            tmo_cnt_r        <= '0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_wr_s || grant_rd_s) begin
                        write_r          <= grant_wr_s;
                        last_was_write_r <= grant_wr_s;
                        addr_r           <= grant_wr_s ? bus.aw_addr_i : bus.ar_addr_i;
                        prot_r           <= grant_wr_s ? bus.aw_prot_i : bus.ar_prot_i;
                        // Reads carry no data and, for APB4, no strobes.
                        wdata_r          <= grant_wr_s ? bus.w_data_i : '0;
                        strb_r           <= grant_wr_s ? bus.w_strb_i : '0;
                        rdata_r          <= '0;
                        psel_r           <= 1'b1;
                        state_r          <= SETUP;
                    end
                end
                SETUP: begin
                    penable_r <= 1'b1;
                    state_r   <= ACCESS;
`ifdef AXI_LITE_TO_APB_TIMEOUT_EN
                    tmo_cnt_r <= '0;
`endif
                end
                ACCESS: begin
                    if (bus.pready_i) begin
                        psel_r    <= 1'b0;
                        penable_r <= 1'b0;
                        resp_r    <= bus.pslverr_i ? 2'b10 : 2'b00;
                        if (!write_r) begin
                            rdata_r <= bus.prdata_i;
                        end
                        b_valid_r <= write_r;
                        r_valid_r <= !write_r;
                        state_r   <= RESP;
`ifdef AXI_LITE_TO_APB_TIMEOUT_EN
                    end else if (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        // Abort: read data stays at the zero loaded on grant.
                        psel_r    <= 1'b0;
                        penable_r <= 1'b0;
                        resp_r    <= 2'b10;
                        b_valid_r <= write_r;
                        r_valid_r <= !write_r;
                        state_r   <= RESP;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
`endif
                    end
                end
                RESP: begin
                    if (write_r ? bus.b_ready_i : bus.r_ready_i) begin
                        b_valid_r <= 1'b0;
                        r_valid_r <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_to_apb.sv
// Directed self-checking bench for axi_lite_to_apb (timeout steps need AXI_LITE_TO_APB_TIMEOUT_EN).
module tb_axi_lite_to_apb;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    logic clk_i = 1'b0;
    logic rst_ni;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_wr;

    axi_lite_to_apb_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

    axi_lite_to_apb #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni         = 1'b0;
        bus.aw_addr_i  = 32'h0;
        bus.aw_prot_i  = 3'b000;
        bus.aw_valid_i = 1'b0;
        bus.w_data_i   = 32'h0;
        bus.w_strb_i   = 4'h0;
        bus.w_valid_i  = 1'b0;
        bus.b_ready_i  = 1'b0;
        bus.ar_addr_i  = 32'h0;
        bus.ar_prot_i  = 3'b000;
        bus.ar_valid_i = 1'b0;
        bus.r_ready_i  = 1'b0;
        bus.pready_i   = 1'b0;
        bus.prdata_i   = 32'h0;
        bus.pslverr_i  = 1'b0;

        // Reset: all outputs zero even with requests pending.
        bus.aw_valid_i = 1'b1;
        bus.w_valid_i  = 1'b1;
        bus.ar_valid_i = 1'b1;
        tick();
        tick();
        check("rst_aw_ready", bus.aw_ready_o, 1'b0);
        check("rst_ar_ready", bus.ar_ready_o, 1'b0);
        check("rst_psel", bus.psel_o, 1'b0);
        check("rst_penable", bus.penable_o, 1'b0);
        check("rst_b_valid", bus.b_valid_o, 1'b0);
        check("rst_r_valid", bus.r_valid_o, 1'b0);
        check("rst_r_data", bus.r_data_o, 32'h0);
        check("rst_paddr", bus.paddr_o, 32'h0);
        bus.aw_valid_i = 1'b0;
        bus.w_valid_i  = 1'b0;
        bus.ar_valid_i = 1'b0;
        rst_ni = 1'b1;
        tick();

        // Single write, zero wait states.
        bus.pready_i   = 1'b1;
        bus.aw_addr_i  = 32'h100;
        bus.aw_prot_i  = 3'b010;
        bus.aw_valid_i = 1'b1;
        bus.w_data_i   = 32'hDEADBEEF;
        bus.w_strb_i   = 4'hF;
        bus.w_valid_i  = 1'b1;
        #1;
        check("wr_aw_ready", bus.aw_ready_o, 1'b1);
        check("wr_w_ready", bus.w_ready_o, 1'b1);
        check("wr_ar_ready", bus.ar_ready_o, 1'b0);
        check("wr_psel_c0", bus.psel_o, 1'b0);
        tick();
        bus.aw_valid_i = 1'b0;
        bus.w_valid_i  = 1'b0;
        check("wr_psel_c1", bus.psel_o, 1'b1);
        check("wr_penable_c1", bus.penable_o, 1'b0);
        check("wr_paddr", bus.paddr_o, 32'h100);
        check("wr_pprot", bus.pprot_o, 3'b010);
        check("wr_pwrite", bus.pwrite_o, 1'b1);
        check("wr_pwdata", bus.pwdata_o, 32'hDEADBEEF);
        check("wr_pstrb", bus.pstrb_o, 4'hF);
        check("wr_aw_ready_setup", bus.aw_ready_o, 1'b0);
        tick();
        check("wr_psel_c2", bus.psel_o, 1'b1);
        check("wr_penable_c2", bus.penable_o, 1'b1);
        check("wr_b_valid_c2", bus.b_valid_o, 1'b0);
        tick();
        check("wr_b_valid_c3", bus.b_valid_o, 1'b1);
        check("wr_b_resp", bus.b_resp_o, 2'b00);
        check("wr_psel_c3", bus.psel_o, 1'b0);
        check("wr_r_valid_c3", bus.r_valid_o, 1'b0);
        bus.b_ready_i = 1'b1;
        tick();
        check("wr_b_valid_c4", bus.b_valid_o, 1'b0);
        bus.b_ready_i = 1'b0;

        // Read with three wait states.
        bus.pready_i   = 1'b0;
        bus.ar_addr_i  = 32'h200;
        bus.ar_valid_i = 1'b1;
        #1;
        check("rd_ar_ready", bus.ar_ready_o, 1'b1);
        check("rd_aw_ready", bus.aw_ready_o, 1'b0);
        tick();
        bus.ar_valid_i = 1'b0;
        check("rd_psel_setup", bus.psel_o, 1'b1);
        check("rd_penable_setup", bus.penable_o, 1'b0);
        check("rd_pwrite", bus.pwrite_o, 1'b0);
        check("rd_pstrb_setup", bus.pstrb_o, 4'h0);
        check("rd_paddr", bus.paddr_o, 32'h200);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("rd_penable_access", bus.penable_o, 1'b1);
            check("rd_pstrb_access", bus.pstrb_o, 4'h0);
            check("rd_r_valid_access", bus.r_valid_o, 1'b0);
            if (i == 3) begin
                bus.pready_i = 1'b1;
                bus.prdata_i = 32'h12345678;
            end
            tick();
        end
        bus.pready_i = 1'b0;
        bus.prdata_i = 32'h0;
        check("rd_r_valid", bus.r_valid_o, 1'b1);
        check("rd_r_data", bus.r_data_o, 32'h12345678);
        check("rd_r_resp", bus.r_resp_o, 2'b00);
        check("rd_psel_resp", bus.psel_o, 1'b0);
        check("rd_penable_resp", bus.penable_o, 1'b0);
        check("rd_b_valid", bus.b_valid_o, 1'b0);
        tick();
        check("rd_r_valid_hold", bus.r_valid_o, 1'b1);
        check("rd_r_data_hold", bus.r_data_o, 32'h12345678);
        bus.r_ready_i = 1'b1;
        tick();
        check("rd_r_valid_done", bus.r_valid_o, 1'b0);
        bus.r_ready_i = 1'b0;

        // Slave error on a read, then a clean write.
        bus.pready_i   = 1'b1;
        bus.pslverr_i  = 1'b1;
        bus.prdata_i   = 32'hA5A5A5A5;
        bus.ar_addr_i  = 32'h300;
        bus.ar_valid_i = 1'b1;
        #1;
        check("err_ar_ready", bus.ar_ready_o, 1'b1);
        tick();
        bus.ar_valid_i = 1'b0;
        tick();
        tick();
        check("err_r_valid", bus.r_valid_o, 1'b1);
        check("err_r_resp", bus.r_resp_o, 2'b10);
        check("err_r_data", bus.r_data_o, 32'hA5A5A5A5);
        bus.pslverr_i = 1'b0;
        bus.r_ready_i = 1'b1;
        tick();
        bus.r_ready_i  = 1'b0;
        bus.aw_addr_i  = 32'h104;
        bus.aw_valid_i = 1'b1;
        bus.w_data_i   = 32'h11223344;
        bus.w_strb_i   = 4'b0011;
        bus.w_valid_i  = 1'b1;
        #1;
        check("err2_aw_ready", bus.aw_ready_o, 1'b1);
        tick();
        bus.aw_valid_i = 1'b0;
        bus.w_valid_i  = 1'b0;
        check("err2_pstrb", bus.pstrb_o, 4'b0011);
        tick();
        tick();
        check("err2_b_valid", bus.b_valid_o, 1'b1);
        check("err2_b_resp", bus.b_resp_o, 2'b00);
        check("err2_r_data_write", bus.r_data_o, 32'h0);
        bus.b_ready_i = 1'b1;
        tick();
        check("err2_b_valid_done", bus.b_valid_o, 1'b0);
        bus.b_ready_i = 1'b0;

        // B channel back-pressure for five cycles with both kinds pending.
        bus.pslverr_i  = 1'b1;
        bus.aw_addr_i  = 32'h108;
        bus.aw_valid_i = 1'b1;
        bus.w_data_i   = 32'h55AA55AA;
        bus.w_strb_i   = 4'hF;
        bus.w_valid_i  = 1'b1;
        #1;
        check("bp_aw_ready", bus.aw_ready_o, 1'b1);
        tick();
        bus.aw_valid_i = 1'b0;
        bus.w_valid_i  = 1'b0;
        tick();
        tick();
        bus.pslverr_i  = 1'b0;
        bus.pready_i   = 1'b0;
        bus.ar_addr_i  = 32'h10C;
        bus.ar_valid_i = 1'b1;
        bus.aw_valid_i = 1'b1;
        bus.w_valid_i  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_b_valid", bus.b_valid_o, 1'b1);
            check("bp_b_resp", bus.b_resp_o, 2'b10);
            check("bp_aw_ready", bus.aw_ready_o, 1'b0);
            check("bp_ar_ready", bus.ar_ready_o, 1'b0);
            check("bp_psel", bus.psel_o, 1'b0);
            tick();
        end
        bus.b_ready_i = 1'b1;
        #1;
        check("bp_ar_ready_resp", bus.ar_ready_o, 1'b0);
        tick();
        bus.b_ready_i = 1'b0;
        check("bp_b_valid_done", bus.b_valid_o, 1'b0);
        check("bp_next_ar_ready", bus.ar_ready_o, 1'b1);
        check("bp_next_aw_ready", bus.aw_ready_o, 1'b0);
        tick();
        bus.ar_valid_i = 1'b0;
        bus.aw_valid_i = 1'b0;
        bus.w_valid_i  = 1'b0;
        check("bp_next_pwrite", bus.pwrite_o, 1'b0);
        check("bp_next_paddr", bus.paddr_o, 32'h10C);
        bus.pready_i = 1'b1;
        bus.prdata_i = 32'hCAFEF00D;
        tick();
        tick();
        check("bp_next_r_valid", bus.r_valid_o, 1'b1);
        check("bp_next_r_data", bus.r_data_o, 32'hCAFEF00D);
        check("bp_next_r_resp", bus.r_resp_o, 2'b00);
        bus.r_ready_i = 1'b1;
        tick();
        bus.r_ready_i = 1'b0;

        // Write and read both pending from reset: grants alternate, write first.
        rst_ni         = 1'b0;
        bus.aw_addr_i  = 32'h400;
        bus.ar_addr_i  = 32'h500;
        bus.w_data_i   = 32'h0F0F0F0F;
        bus.aw_valid_i = 1'b1;
        bus.w_valid_i  = 1'b1;
        bus.ar_valid_i = 1'b1;
        bus.pready_i   = 1'b1;
        bus.b_ready_i  = 1'b1;
        bus.r_ready_i  = 1'b1;
        tick();
        tick();
        check("arb_rst_aw_ready", bus.aw_ready_o, 1'b0);
        check("arb_rst_r_valid", bus.r_valid_o, 1'b0);
        rst_ni = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_wr = ((k % 2) == 0);
            check("arb_aw_ready", bus.aw_ready_o, exp_wr);
            check("arb_w_ready", bus.w_ready_o, exp_wr);
            check("arb_ar_ready", bus.ar_ready_o, !exp_wr);
            tick();
            check("arb_pwrite", bus.pwrite_o, exp_wr);
            check("arb_psel", bus.psel_o, 1'b1);
            tick();
            tick();
            check("arb_b_valid", bus.b_valid_o, exp_wr);
            check("arb_r_valid", bus.r_valid_o, !exp_wr);
            tick();
        end
        bus.w_valid_i  = 1'b0;
        bus.ar_valid_i = 1'b0;
        #1;
        check("aw_only_aw_ready", bus.aw_ready_o, 1'b0);
        check("aw_only_w_ready", bus.w_ready_o, 1'b0);
        tick();
        check("aw_only_psel", bus.psel_o, 1'b0);
        bus.aw_valid_i = 1'b0;
        bus.b_ready_i  = 1'b0;
        bus.r_ready_i  = 1'b0;

        // Reset in the middle of ACCESS drops the transfer.
        bus.pready_i   = 1'b0;
        bus.aw_addr_i  = 32'h600;
        bus.aw_valid_i = 1'b1;
        bus.w_valid_i  = 1'b1;
        tick();
        bus.aw_valid_i = 1'b0;
        bus.w_valid_i  = 1'b0;
        tick();
        check("mid_psel_access", bus.psel_o, 1'b1);
        check("mid_penable_access", bus.penable_o, 1'b1);
        rst_ni = 1'b0;
        tick();
        check("mid_psel_reset", bus.psel_o, 1'b0);
        check("mid_penable_reset", bus.penable_o, 1'b0);
        check("mid_b_valid_reset", bus.b_valid_o, 1'b0);
        rst_ni = 1'b1;
        tick();
        tick();
        check("mid_psel_after", bus.psel_o, 1'b0);
        check("mid_b_valid_after", bus.b_valid_o, 1'b0);

        // Slave never ready.
        bus.ar_addr_i  = 32'h700;
        bus.ar_valid_i = 1'b1;
        bus.prdata_i   = 32'hFFFFFFFF;
        tick();
        bus.ar_valid_i = 1'b0;
        tick();
`ifdef AXI_LITE_TO_APB_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            check("tmo_penable", bus.penable_o, 1'b1);
            check("tmo_r_valid_wait", bus.r_valid_o, 1'b0);
            tick();
        end
        check("tmo_r_valid", bus.r_valid_o, 1'b1);
        check("tmo_r_resp", bus.r_resp_o, 2'b10);
        check("tmo_r_data", bus.r_data_o, 32'h0);
        check("tmo_psel", bus.psel_o, 1'b0);
        check("tmo_penable_drop", bus.penable_o, 1'b0);
`else
        for (int i = 0; i < 12; i++) begin
            check("wait_penable", bus.penable_o, 1'b1);
            check("wait_r_valid", bus.r_valid_o, 1'b0);
            tick();
        end
        bus.pready_i = 1'b1;
        bus.prdata_i = 32'h0BADF00D;
        tick();
        bus.pready_i = 1'b0;
        check("wait_r_valid_done", bus.r_valid_o, 1'b1);
        check("wait_r_data", bus.r_data_o, 32'h0BADF00D);
        check("wait_r_resp", bus.r_resp_o, 2'b00);
`endif
        bus.r_ready_i = 1'b1;
        tick();
        check("final_r_valid", bus.r_valid_o, 1'b0);
        bus.r_ready_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
